// File: rtl/gshare_btb_predictor.sv
// ============================================================================
// Module   : gshare_btb_predictor
// Purpose  : Set-associative BTB plus gshare PHT with speculative GHR and
//            MEM-stage repair. Optional return stack enabled by BP_RAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gshare_btb_predictor #(
  parameter int S_INDEX   = 6,
  parameter int WAYS      = 2,
  parameter int GHR_W     = 8,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic             if_valid,
  output logic             if_btb_hit,
  output logic             if_pred_taken,
  output logic [31:0]      if_pred_target,
  output logic [GHR_W-1:0] if_pht_index,
  output logic [GHR_W-1:0] if_ghr_snapshot,
  input  logic             mem_valid,
  input  logic [31:0]      mem_pc,
  input  logic             mem_is_branch,
  input  logic             mem_is_jal,
  input  logic             mem_is_jalr,
  input  logic             mem_is_call,
  input  logic             mem_is_ret,
  input  logic             mem_taken,
  input  logic [31:0]      mem_target,
  input  logic             mem_pred_taken,
  input  logic [31:0]      mem_pred_target,
  input  logic [GHR_W-1:0] mem_pht_index,
  input  logic [GHR_W-1:0] mem_ghr_snapshot,
  output logic             mem_mispredict,
  output logic [31:0]      mem_redirect_pc
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 30 - S_INDEX;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PHT_N = 1 << GHR_W;

  localparam logic [1:0]       c_TYPE_COND = 2'b00;
  localparam logic [1:0]       c_TYPE_JUMP = 2'b01;
  localparam logic [1:0]       c_TYPE_CALL = 2'b10;
  localparam logic [1:0]       c_TYPE_RET  = 2'b11;
  localparam logic [WAY_W-1:0] c_LAST_WAY  = WAY_W'(WAYS - 1);

  logic [WAYS-1:0]  r_valid [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [30:0]      r_tgt   [SETS][WAYS];
  logic [1:0]       r_type  [SETS][WAYS];
  logic [WAY_W-1:0] r_rr    [SETS];
  logic [1:0]       r_pht   [PHT_N];
  logic [GHR_W-1:0] r_ghr;

  logic             w_ras_valid;
  logic [31:0]      w_ras_top;

  // ---------------------------------------------------------------- fetch
  logic [S_INDEX-1:0] w_if_set;
  logic [TAG_W-1:0]   w_if_tag;
  logic               w_if_hit;
  logic [WAY_W-1:0]   w_if_way;
  logic [1:0]         w_if_type;
  logic [GHR_W-1:0]   w_if_idx;
  logic               w_if_cond_hit;

  assign w_if_set = if_pc[S_INDEX+1:2];
  assign w_if_tag = if_pc[31:S_INDEX+2];
  assign w_if_idx = if_pc[GHR_W+1:2] ^ r_ghr;

  always_comb begin
    w_if_hit = 1'b0;
    w_if_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_if_hit && r_valid[w_if_set][w] && (r_tag[w_if_set][w] == w_if_tag)) begin
        w_if_hit = 1'b1;
        w_if_way = WAY_W'(w);
      end
    end
  end

  assign w_if_type     = r_type[w_if_set][w_if_way];
  assign w_if_cond_hit = w_if_hit && (w_if_type == c_TYPE_COND);

  // Non-conditional hits are always taken; a ret prefers the stack top when one exists
  always_comb begin
    if_pred_taken  = 1'b0;
    if_pred_target = if_pc + 32'd4;
    if (w_if_hit) begin
      if_pred_taken = (w_if_type == c_TYPE_COND) ? r_pht[w_if_idx][1] : 1'b1;
      if ((w_if_type == c_TYPE_RET) && w_ras_valid)
        if_pred_target = w_ras_top;
      else
        if_pred_target = {r_tgt[w_if_set][w_if_way], 1'b0};
    end
  end

  assign if_btb_hit      = w_if_hit;
  assign if_pht_index    = w_if_idx;
  assign if_ghr_snapshot = r_ghr;

  // ---------------------------------------------------------------- resolve
  logic               w_ctrl;
  logic [31:0]        w_mem_tgt;
  logic [31:0]        w_mem_seq;
  logic               w_mispred;
  logic [1:0]         w_mem_type;
  logic [S_INDEX-1:0] w_mem_set;
  logic [TAG_W-1:0]   w_mem_tag;
  logic               w_mem_hit;
  logic [WAY_W-1:0]   w_mem_hit_way;
  logic               w_inv_found;
  logic [WAY_W-1:0]   w_inv_way;
  logic [WAY_W-1:0]   w_alloc_way;
  logic [WAY_W-1:0]   w_rr_cur;
  logic [WAY_W-1:0]   w_rr_next;
  logic               w_btb_write;
  logic               w_rr_adv;

  assign w_ctrl    = mem_valid & (mem_is_branch | mem_is_jal | mem_is_jalr |
                                  mem_is_call | mem_is_ret);
  assign w_mem_tgt = mem_target & 32'hFFFF_FFFE;
  assign w_mem_seq = mem_pc + 32'd4;
  assign w_mispred = w_ctrl & ((mem_pred_taken != mem_taken) |
                               (mem_taken & (mem_pred_target != w_mem_tgt)));

  assign mem_mispredict  = w_mispred;
  assign mem_redirect_pc = mem_taken ? w_mem_tgt : w_mem_seq;

  always_comb begin
    w_mem_type = c_TYPE_JUMP;
    if (mem_is_ret)         w_mem_type = c_TYPE_RET;
    else if (mem_is_call)   w_mem_type = c_TYPE_CALL;
    else if (mem_is_branch) w_mem_type = c_TYPE_COND;
  end

  assign w_mem_set = mem_pc[S_INDEX+1:2];
  assign w_mem_tag = mem_pc[31:S_INDEX+2];

  always_comb begin
    w_mem_hit     = 1'b0;
    w_mem_hit_way = '0;
    w_inv_found   = 1'b0;
    w_inv_way     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_mem_hit && r_valid[w_mem_set][w] && (r_tag[w_mem_set][w] == w_mem_tag)) begin
        w_mem_hit     = 1'b1;
        w_mem_hit_way = WAY_W'(w);
      end
      if (!w_inv_found && !r_valid[w_mem_set][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

  assign w_rr_cur    = r_rr[w_mem_set];
  assign w_rr_next   = (w_rr_cur == c_LAST_WAY) ? '0 : w_rr_cur + 1'b1;
  assign w_alloc_way = w_mem_hit ? w_mem_hit_way : (w_inv_found ? w_inv_way : w_rr_cur);
  assign w_btb_write = w_ctrl & mem_taken;
  assign w_rr_adv    = w_btb_write & ~w_mem_hit & ~w_inv_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w]  <= '0;
          r_tgt[s][w]  <= '0;
          r_type[s][w] <= c_TYPE_COND;
        end
      end
    end else if (w_btb_write) begin
      r_valid[w_mem_set][w_alloc_way] <= 1'b1;
      r_tag[w_mem_set][w_alloc_way]   <= w_mem_tag;
      r_tgt[w_mem_set][w_alloc_way]   <= w_mem_tgt[31:1];
      r_type[w_mem_set][w_alloc_way]  <= w_mem_type;
      if (w_rr_adv)
        r_rr[w_mem_set] <= w_rr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++)
        r_pht[i] <= 2'b01;
    end else if (w_ctrl && mem_is_branch) begin
      if (mem_taken && (r_pht[mem_pht_index] != 2'b11))
        r_pht[mem_pht_index] <= r_pht[mem_pht_index] + 2'b01;
      else if (!mem_taken && (r_pht[mem_pht_index] != 2'b00))
        r_pht[mem_pht_index] <= r_pht[mem_pht_index] - 2'b01;
    end
  end

  // Repair from MEM outranks the speculative fetch-side shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ghr <= '0;
    else if (w_mispred && mem_is_branch)
      r_ghr <= {mem_ghr_snapshot[GHR_W-2:0], mem_taken};
    else if (w_mispred)
      r_ghr <= mem_ghr_snapshot;
    else if (if_valid && w_if_cond_hit)
      r_ghr <= {r_ghr[GHR_W-2:0], if_pred_taken};
  end

`ifdef BP_RAS_EN
  localparam int               RP_W       = $clog2(RAS_DEPTH);
  localparam logic [RP_W:0]    c_RAS_FULL = (RP_W + 1)'(RAS_DEPTH);

  logic [31:0]     r_ras [RAS_DEPTH];
  logic [RP_W-1:0] r_ras_ptr;
  logic [RP_W:0]   r_ras_cnt;
  logic            w_pop;
  logic            w_push;
  logic [RP_W-1:0] w_ptr_pop;
  logic [RP_W-1:0] w_top_ptr;
  logic [RP_W:0]   w_cnt_pop;

  assign w_pop       = w_ctrl & mem_is_ret & (r_ras_cnt != '0);
  assign w_push      = w_ctrl & mem_is_call;
  assign w_ptr_pop   = w_pop ? r_ras_ptr - 1'b1 : r_ras_ptr;
  assign w_cnt_pop   = w_pop ? r_ras_cnt - 1'b1 : r_ras_cnt;
  assign w_top_ptr   = r_ras_ptr - 1'b1;
  assign w_ras_top   = r_ras[w_top_ptr];
  assign w_ras_valid = (r_ras_cnt != '0);

  // Pop is applied first so a call+ret replaces the top entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        r_ras[i] <= '0;
    end else if (w_push) begin
      r_ras[w_ptr_pop] <= w_mem_seq;
      r_ras_ptr        <= w_ptr_pop + 1'b1;
      r_ras_cnt        <= (w_cnt_pop == c_RAS_FULL) ? w_cnt_pop : w_cnt_pop + 1'b1;
    end else if (w_pop) begin
      r_ras_ptr <= w_ptr_pop;
      r_ras_cnt <= w_cnt_pop;
    end
  end
`else
  localparam int RP_W = $clog2(RAS_DEPTH);

  logic [RP_W:0] w_ras_cnt;

  assign w_ras_cnt   = '0;
  assign w_ras_valid = (w_ras_cnt != '0);
  assign w_ras_top   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gshare_btb_predictor.sv
// Scoreboard bench for gshare_btb_predictor (default parameters).
`default_nettype none

module tb_gshare_btb_predictor;

  localparam logic [4:0] K_BR   = 5'b10000;
  localparam logic [4:0] K_JAL  = 5'b01000;
  localparam logic [4:0] K_JALR = 5'b00100;
  localparam logic [4:0] K_CALL = 5'b00010;
  localparam logic [4:0] K_RET  = 5'b00001;

  logic        clk, rst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_btb_hit, if_pred_taken;
  logic [31:0] if_pred_target;
  logic [7:0]  if_pht_index, if_ghr_snapshot;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_is_branch, mem_is_jal, mem_is_jalr, mem_is_call, mem_is_ret;
  logic        mem_taken;
  logic [31:0] mem_target;
  logic        mem_pred_taken;
  logic [31:0] mem_pred_target;
  logic [7:0]  mem_pht_index, mem_ghr_snapshot;
  logic        mem_mispredict;
  logic [31:0] mem_redirect_pc;

  int checks = 0;
  int errors = 0;

  string       sb_name[$];
  logic [31:0] sb_exp[$];
  logic [31:0] sb_act[$];

  gshare_btb_predictor #(.S_INDEX(6), .WAYS(2), .GHR_W(8), .RAS_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_valid(if_valid),
    .if_btb_hit(if_btb_hit), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .if_pht_index(if_pht_index),
    .if_ghr_snapshot(if_ghr_snapshot),
    .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_is_branch(mem_is_branch), .mem_is_jal(mem_is_jal),
    .mem_is_jalr(mem_is_jalr), .mem_is_call(mem_is_call), .mem_is_ret(mem_is_ret),
    .mem_taken(mem_taken), .mem_target(mem_target),
    .mem_pred_taken(mem_pred_taken), .mem_pred_target(mem_pred_target),
    .mem_pht_index(mem_pht_index), .mem_ghr_snapshot(mem_ghr_snapshot),
    .mem_mispredict(mem_mispredict), .mem_redirect_pc(mem_redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_v(input string n, input logic [31:0] e);
    sb_name.push_back(n);
    sb_exp.push_back(e);
  endtask

  task automatic observe(input logic [31:0] a);
    sb_act.push_back(a);
  endtask

  task automatic mem_idle();
    mem_valid = 1'b0; mem_pc = '0;
    {mem_is_branch, mem_is_jal, mem_is_jalr, mem_is_call, mem_is_ret} = '0;
    mem_taken = 1'b0; mem_target = '0;
    mem_pred_taken = 1'b0; mem_pred_target = '0;
    mem_pht_index = '0; mem_ghr_snapshot = '0;
  endtask

  task automatic mem_set(input logic [31:0] pc, input logic [4:0] cls, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic [7:0] idx, input logic [7:0] snap);
    mem_valid = 1'b1; mem_pc = pc;
    {mem_is_branch, mem_is_jal, mem_is_jalr, mem_is_call, mem_is_ret} = cls;
    mem_taken = tk; mem_target = tgt;
    mem_pred_taken = ptk; mem_pred_target = ptgt;
    mem_pht_index = idx; mem_ghr_snapshot = snap;
  endtask

  task automatic train(input logic [31:0] pc, input logic [4:0] cls, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                       input logic [7:0] idx, input logic [7:0] snap);
    @(negedge clk);
    if_valid = 1'b0;
    mem_set(pc, cls, tk, tgt, ptk, ptgt, idx, snap);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic v);
    @(negedge clk);
    mem_idle();
    if_pc = pc;
    if_valid = v;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_idle();
    if_valid = 1'b0;
    if_pc = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    string n; logic [31:0] e, a;
    do_reset();
    fetch(32'h100, 1'b1);
    expect_v("rst_hit", 32'd0);        observe(32'(if_btb_hit));
    expect_v("rst_taken", 32'd0);      observe(32'(if_pred_taken));
    expect_v("rst_target", 32'h104);   observe(if_pred_target);
    expect_v("rst_ghr", 32'd0);        observe(32'(if_ghr_snapshot));
    expect_v("rst_idx", 32'h40);       observe(32'(if_pht_index));
    expect_v("rst_mispred", 32'd0);    observe(32'(mem_mispredict));
    train(32'h100, K_JAL, 1'b1, 32'h500, 1'b1, 32'h500, 8'h0, 8'h0);
    fetch(32'h100, 1'b0);
    expect_v("pre_async_hit", 32'd1);  observe(32'(if_btb_hit));
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    expect_v("async_rst_hit", 32'd0);  observe(32'(if_btb_hit));
    while (sb_exp.size() > 0) begin
      n = sb_name.pop_front(); e = sb_exp.pop_front(); checks++;
      if (sb_act.size() == 0) begin
        errors++; $display("FAIL %s: no observation, required %h", n, e);
      end else begin
        a = sb_act.pop_front();
        if (a !== e) begin errors++; $display("FAIL %s: got %h required %h", n, a, e); end
      end
    end
  endtask

  task automatic test_train_target();
    string n; logic [31:0] e, a;
    do_reset();
    train(32'h200, K_BR, 1'b1, 32'h300, 1'b0, 32'h204, 8'h80, 8'h00);
    expect_v("tt_mispred", 32'd1);     observe(32'(mem_mispredict));
    expect_v("tt_redirect", 32'h300);  observe(mem_redirect_pc);
    fetch(32'h200, 1'b0);
    expect_v("tt_hit", 32'd1);         observe(32'(if_btb_hit));
    expect_v("tt_target", 32'h300);    observe(if_pred_target);
    expect_v("tt_taken", 32'd0);       observe(32'(if_pred_taken));
    expect_v("tt_ghr", 32'h01);        observe(32'(if_ghr_snapshot));
    while (sb_exp.size() > 0) begin
      n = sb_name.pop_front(); e = sb_exp.pop_front(); checks++;
      if (sb_act.size() == 0) begin
        errors++; $display("FAIL %s: no observation, required %h", n, e);
      end else begin
        a = sb_act.pop_front();
        if (a !== e) begin errors++; $display("FAIL %s: got %h required %h", n, a, e); end
      end
    end
  endtask

  task automatic test_counter();
    string n; logic [31:0] e, a;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      train(32'h200, K_BR, 1'b1, 32'h300, 1'b1, 32'h300, 8'h80, 8'h00);
      expect_v("ctr_train_mispred", 32'd0); observe(32'(mem_mispredict));
    end
    fetch(32'h200, 1'b0);
    expect_v("ctr_11_taken", 32'd1);   observe(32'(if_pred_taken));
    expect_v("ctr_11_target", 32'h300); observe(if_pred_target);
    expect_v("ctr_idx", 32'h80);       observe(32'(if_pht_index));
    train(32'h200, K_BR, 1'b0, 32'h300, 1'b1, 32'h300, 8'h80, 8'h00);
    expect_v("ctr_nt_mispred", 32'd1); observe(32'(mem_mispredict));
    expect_v("ctr_nt_redirect", 32'h204); observe(mem_redirect_pc);
    fetch(32'h200, 1'b0);
    expect_v("ctr_10_taken", 32'd1);   observe(32'(if_pred_taken));
    train(32'h200, K_BR, 1'b0, 32'h300, 1'b1, 32'h300, 8'h80, 8'h00);
    fetch(32'h200, 1'b0);
    expect_v("ctr_01_taken", 32'd0);   observe(32'(if_pred_taken));
    while (sb_exp.size() > 0) begin
      n = sb_name.pop_front(); e = sb_exp.pop_front(); checks++;
      if (sb_act.size() == 0) begin
        errors++; $display("FAIL %s: no observation, required %h", n, e);
      end else begin
        a = sb_act.pop_front();
        if (a !== e) begin errors++; $display("FAIL %s: got %h required %h", n, a, e); end
      end
    end
  endtask

  task automatic test_replacement();
    string n; logic [31:0] e, a;
    logic [31:0] pcs [4];
    pcs[0] = 32'h200; pcs[1] = 32'h300; pcs[2] = 32'h400; pcs[3] = 32'h500;
    do_reset();
    for (int i = 0; i < 3; i++)
      train(pcs[i], K_JAL, 1'b1, 32'h1000 * (i + 1), 1'b1, 32'h1000 * (i + 1), 8'h0, 8'h0);
    fetch(pcs[0], 1'b0);
    expect_v("rr_a_evicted", 32'd0);   observe(32'(if_btb_hit));
    expect_v("rr_a_target", 32'h204);  observe(if_pred_target);
    expect_v("rr_a_taken", 32'd0);     observe(32'(if_pred_taken));
    fetch(pcs[1], 1'b0);
    expect_v("rr_b_hit", 32'd1);       observe(32'(if_btb_hit));
    expect_v("rr_b_target", 32'h2000); observe(if_pred_target);
    fetch(pcs[2], 1'b0);
    expect_v("rr_c_target", 32'h3000); observe(if_pred_target);
    expect_v("rr_c_taken", 32'd1);     observe(32'(if_pred_taken));
    train(pcs[3], K_JAL, 1'b1, 32'h4000, 1'b1, 32'h4000, 8'h0, 8'h0);
    fetch(pcs[1], 1'b0);
    expect_v("rr_b_evicted", 32'd0);   observe(32'(if_btb_hit));
    fetch(pcs[2], 1'b0);
    expect_v("rr_c_kept", 32'd1);      observe(32'(if_btb_hit));
    fetch(pcs[3], 1'b0);
    expect_v("rr_d_target", 32'h4000); observe(if_pred_target);
    while (sb_exp.size() > 0) begin
      n = sb_name.pop_front(); e = sb_exp.pop_front(); checks++;
      if (sb_act.size() == 0) begin
        errors++; $display("FAIL %s: no observation, required %h", n, e);
      end else begin
        a = sb_act.pop_front();
        if (a !== e) begin errors++; $display("FAIL %s: got %h required %h", n, a, e); end
      end
    end
  endtask

  task automatic test_ghr();
    string n; logic [31:0] e, a;
    do_reset();
    for (int i = 0; i < 2; i++)
      train(32'h200, K_BR, 1'b1, 32'h300, 1'b1, 32'h300, 8'h85, 8'h00);
    train(32'h1004, K_JAL, 1'b1, 32'h2000, 1'b0, 32'h1008, 8'h00, 8'h05);
    expect_v("ghr_jump_mispred", 32'd1); observe(32'(mem_mispredict));
    fetch(32'h200, 1'b1);
    expect_v("ghr_before", 32'h05);    observe(32'(if_ghr_snapshot));
    expect_v("ghr_fetch_idx", 32'h85); observe(32'(if_pht_index));
    expect_v("ghr_fetch_taken", 32'd1); observe(32'(if_pred_taken));
    fetch(32'h200, 1'b1);
    mem_set(32'h200, K_BR, 1'b0, 32'h300, 1'b1, 32'h300, 8'h85, 8'h05);
    #1;
    expect_v("ghr_shifted", 32'h0B);   observe(32'(if_ghr_snapshot));
    expect_v("ghr_repair_mispred", 32'd1); observe(32'(mem_mispredict));
    fetch(32'h200, 1'b0);
    expect_v("ghr_repaired", 32'h0A);  observe(32'(if_ghr_snapshot));
    while (sb_exp.size() > 0) begin
      n = sb_name.pop_front(); e = sb_exp.pop_front(); checks++;
      if (sb_act.size() == 0) begin
        errors++; $display("FAIL %s: no observation, required %h", n, e);
      end else begin
        a = sb_act.pop_front();
        if (a !== e) begin errors++; $display("FAIL %s: got %h required %h", n, a, e); end
      end
    end
  endtask

  task automatic test_ras();
    string n; logic [31:0] e, a;
    logic [31:0] ret_tgt;
`ifdef BP_RAS_EN
    ret_tgt = 32'h404;
`else
    ret_tgt = 32'h900;
`endif
    do_reset();
    train(32'h800, K_JALR | K_RET, 1'b1, 32'h900, 1'b1, 32'h900, 8'h0, 8'h0);
    expect_v("ras_ret_mispred", 32'd0); observe(32'(mem_mispredict));
    train(32'h400, K_JAL | K_CALL, 1'b1, 32'h1000, 1'b1, 32'h1000, 8'h0, 8'h0);
    expect_v("ras_call_mispred", 32'd0); observe(32'(mem_mispredict));
    fetch(32'h800, 1'b0);
    expect_v("ras_hit", 32'd1);        observe(32'(if_btb_hit));
    expect_v("ras_taken", 32'd1);      observe(32'(if_pred_taken));
    expect_v("ras_target", ret_tgt);   observe(if_pred_target);
    while (sb_exp.size() > 0) begin
      n = sb_name.pop_front(); e = sb_exp.pop_front(); checks++;
      if (sb_act.size() == 0) begin
        errors++; $display("FAIL %s: no observation, required %h", n, e);
      end else begin
        a = sb_act.pop_front();
        if (a !== e) begin errors++; $display("FAIL %s: got %h required %h", n, a, e); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_pc = '0;
    if_valid = 1'b0;
    mem_idle();
    test_reset();
    test_train_target();
    test_counter();
    test_replacement();
    test_ghr();
    test_ras();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gshare_btb_predictor.md
# gshare_btb_predictor

Parametrised next-generation branch predictor for the IF/MEM pipeline. It provides a WAYS-way set-associative BTB with per-set round-robin replacement and stored branch type, and a gshare PHT indexed by PC XOR a speculative global history register, with history recovery on misprediction. Fetch prediction is combinational from `if_pc`. Training, history repair and redirect are resolved from the MEM stage.

## Interface
- `S_INDEX`, 6: BTB set-index bits (2^S_INDEX sets).
- `WAYS`, 2: BTB associativity (1..8).
- `GHR_W`, 8: history length; the PHT has 2^GHR_W 2-bit counters.
- `RAS_DEPTH`, 8: return stack entries (power of 2); used only with `BP_RAS_EN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_pc` in 32: fetch PC.
- `if_valid` in 1: a fetch occurs this cycle.
- `if_btb_hit` out 1: tag match in some valid way.
- `if_pred_taken` out 1: predicted redirect.
- `if_pred_target` out 32: predicted target.
- `if_pht_index` out GHR_W: index used for this fetch; the pipe carries it to MEM.
- `if_ghr_snapshot` out GHR_W: GHR before this fetch's update; the pipe carries it.
- `mem_valid` in 1: the MEM instruction is valid.
- `mem_pc` in 32: PC of the MEM instruction.
- `mem_is_branch`, `mem_is_jal`, `mem_is_jalr`, `mem_is_call`, `mem_is_ret` in 1 each: instruction class. Call and ret qualify jal/jalr.
- `mem_taken` in 1: actual direction; 1 for all jumps.
- `mem_target` in 32: actual target.
- `mem_pred_taken` in 1, `mem_pred_target` in 32: the IF prediction, piped.
- `mem_pht_index`, `mem_ghr_snapshot` in GHR_W: the IF values, piped.
- `mem_mispredict` out 1: redirect required.
- `mem_redirect_pc` out 32: the correct next PC.

## Operation
- Indexing: tag = pc[31:S_INDEX+2]; set = pc[S_INDEX+1:2].
- BTB entry: valid, tag, target[31:1], type. Type encoding: 00 cond, 01 jump, 10 call, 11 ret.
- PHT index = if_pc[GHR_W+1:2] ^ ghr.
- Prediction:
  - Hit on type cond: taken = pht[idx][1].
  - Hit on any other type: always taken.
  - Miss: not taken, target = if_pc+4.
- Counters reset to 01 (weakly not-taken) and saturate at 00 and 11.
- Control instruction at MEM: `mem_valid` & any `mem_is_*`.
- Mispredict = control & ((mem_pred_taken != mem_taken) | (mem_taken & mem_pred_target != {mem_target[31:1],1'b0})).
- Redirect PC = mem_taken ? {mem_target[31:1],0} : mem_pc+4.
- Training, on a control instruction at MEM:
  - Branch: pht[mem_pht_index] increments if taken, decrements if not.
  - Taken, BTB hit: rewrite target and type in the hit way.
  - Taken, BTB miss: allocate the lowest invalid way; if all ways are valid, use the set's round-robin pointer, then advance the pointer mod WAYS.
  - Not-taken branch on a BTB miss: no allocation.
- GHR update, highest priority first:
  - Mispredicted cond branch: ghr <= {mem_ghr_snapshot[GHR_W-2:0], mem_taken}.
  - Mispredicted non-cond instruction: ghr <= mem_ghr_snapshot.
  - Otherwise, if_valid & hit & type cond: ghr <= {ghr[GHR_W-2:0], if_pred_taken}.
- Reset:
  - All BTB valid bits = 0, round-robin pointers = 0, GHR = 0, PHT = 01.
  - With RAS: pointer = 0, count = 0.
  - IF outputs are then miss / not-taken / pc+4, and `mem_mispredict` = 0 unless MEM inputs assert.

## Timing
- Reads are combinational: IF outputs are valid in the same cycle as `if_pc`.
- All array, GHR, pointer and RAS writes happen on the rising clk edge.
- Same-cycle MEM write and IF read of the same entry: IF sees the old value.
- `mem_mispredict` and `mem_redirect_pc` are combinational from MEM inputs, with 0-cycle latency.
- Prediction latency is 0 cycles. A trained entry is visible to the fetch in the next cycle.
- `rst` asserted mid-operation clears state immediately; an in-flight update in that cycle is lost.

## Configuration
- `BP_RAS_EN` defined:
  - A RAS_DEPTH-entry stack is maintained non-speculatively at MEM.
  - A call pushes mem_pc+4; a ret pops.
  - Overflow wraps and overwrites the oldest entry, with count saturating at RAS_DEPTH.
  - Pop on empty is ignored.
  - A BTB hit of type ret with count>0 predicts target = stack top; otherwise it uses the BTB target.
  - Simultaneous call and ret on one instruction: pop then push.
- `BP_RAS_EN` undefined: no stack logic; a ret uses the BTB target.

## Test plan
- Reset, then if_pc=0x100 -> if_btb_hit=0, if_pred_taken=0, if_pred_target=0x104, if_ghr_snapshot=0.
- Taken branch at MEM, pc=0x200, target 0x300, pred_taken=0 -> mispredict=1, redirect=0x300. The next cycle, if_pc=0x200 hits with target 0x300.
- Branch at 0x200 trained taken twice -> counter 01→10→11; prediction taken. One not-taken -> counter 10, still taken.
- With WAYS=2, three taken branches mapping to one set (0x200, 0x200+2^(S_INDEX+2), 0x200+2·2^(S_INDEX+2)) -> the third evicts way 0; round-robin pointer = 1.
- GHR=0x05; fetch of a cond hit predicted taken -> GHR=0x0B. Then a mispredict with snapshot 0x05, taken=0 -> GHR=0x0A, even with a concurrent fetch update.
- With `BP_RAS_EN`: call at 0x400 resolves, then fetch of a ret-type hit at 0x800 -> if_pred_target=0x404. Without the macro -> the stored BTB target.
